// File: rtl/div_radix2.sv
// Iterative radix-2 restoring divider for MIPS DIV/DIVU.
// Retires one quotient bit per cycle; remainder goes to HI and quotient to LO.
module div_radix2 #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             ack,
  input  logic             flush,
  output logic             div_stall,
  output logic             result_valid,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e           state_q;
  logic [CntW-1:0]  cnt_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvs_q;
  logic             sign_q_q;
  logic             sign_r_q;
  logic             result_valid_q;
  logic [WIDTH-1:0] quotient_q;
  logic [WIDTH-1:0] remainder_q;

  // Operand magnitudes and result signs, evaluated on the acceptance cycle.
  logic             dvd_neg;
  logic             dvs_neg;
  logic [WIDTH-1:0] dvd_abs;
  logic [WIDTH-1:0] dvs_abs;
  logic             divisor_zero;

  always_comb begin
    dvd_neg      = is_signed & dividend[WIDTH-1];
    dvs_neg      = is_signed & divisor[WIDTH-1];
    dvd_abs      = dvd_neg ? -dividend : dividend;
    dvs_abs      = dvs_neg ? -divisor : divisor;
    divisor_zero = (divisor == '0);
  end

  // One restoring step: the next dividend bit enters the partial remainder and the
  // divisor is trial-subtracted; a set MSB on the difference is the borrow.
  logic [WIDTH:0]   partial;
  logic [WIDTH:0]   diff;
  logic             borrow;
  logic [WIDTH-1:0] rem_nxt;
  logic [WIDTH-1:0] quo_nxt;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;

  always_comb begin
    partial = {rem_q, quo_q[WIDTH-1]};
    diff    = partial - {1'b0, dvs_q};
    borrow  = diff[WIDTH];
    rem_nxt = borrow ? partial[WIDTH-1:0] : diff[WIDTH-1:0];
    quo_nxt = {quo_q[WIDTH-2:0], ~borrow};
    quo_fix = sign_q_q ? -quo_nxt : quo_nxt;
    rem_fix = sign_r_q ? -rem_nxt : rem_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= StIdle;
      cnt_q          <= '0;
      rem_q          <= '0;
      quo_q          <= '0;
      dvs_q          <= '0;
      sign_q_q       <= 1'b0;
      sign_r_q       <= 1'b0;
      result_valid_q <= 1'b0;
      quotient_q     <= '0;
      remainder_q    <= '0;
    end else if (flush) begin
      state_q        <= StIdle;
      cnt_q          <= '0;
      result_valid_q <= 1'b0;
      quotient_q     <= '0;
      remainder_q    <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            if (divisor_zero) begin
              // Divide by zero skips iteration: LO all ones, HI the raw dividend.
              state_q        <= StDone;
              result_valid_q <= 1'b1;
              quotient_q     <= '1;
              remainder_q    <= dividend;
            end else begin
              state_q  <= StBusy;
              cnt_q    <= '0;
              rem_q    <= '0;
              quo_q    <= dvd_abs;
              dvs_q    <= dvs_abs;
              sign_q_q <= dvd_neg ^ dvs_neg;
              sign_r_q <= dvd_neg;
            end
          end
        end
        StBusy: begin
          rem_q <= rem_nxt;
          quo_q <= quo_nxt;
          cnt_q <= cnt_q + CntW'(1);
          if (cnt_q == CntLast) begin
            state_q        <= StDone;
            result_valid_q <= 1'b1;
            quotient_q     <= quo_fix;
            remainder_q    <= rem_fix;
          end
        end
        StDone: begin
          if (ack) begin
            state_q        <= StIdle;
            result_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q        <= StIdle;
          result_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Stall is dropped in DONE so the E stage can advance and hand the result over.
  assign div_stall    = ~rst & ~flush &
                        (((state_q == StIdle) & start) | (state_q == StBusy));
  assign result_valid = result_valid_q;
  assign quotient     = quotient_q;
  assign remainder    = remainder_q;

endmodule

// File: tb/tb_div_radix2.sv
// Bench for div_radix2: transaction-level reference model with a per-cycle compare
// process, plus directed vectors with hand-computed results.
module tb_div_radix2;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         is_signed;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         ack;
  logic         flush;
  logic         div_stall;
  logic         result_valid;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;

  div_radix2 #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .is_signed    (is_signed),
    .dividend     (dividend),
    .divisor      (divisor),
    .ack          (ack),
    .flush        (flush),
    .div_stall    (div_stall),
    .result_valid (result_valid),
    .quotient     (quotient),
    .remainder    (remainder)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  // Reference result from plain arithmetic: truncating signed division, remainder
  // takes the dividend's sign; 64-bit math makes MIN/-1 wrap naturally.
  function automatic logic [2*W-1:0] ref_qr(input logic s, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
    longint       sa;
    longint       sb;
    logic [W-1:0] q;
    logic [W-1:0] r;
    if (b == '0) begin
      q = '1;
      r = a;
    end else if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = W'(sa / sb);
      r  = W'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {q, r};
  endfunction

  // Transaction model: an accepted divide reports W+1 cycles later (1 for zero divisor).
  logic           m_busy;
  logic           m_valid;
  int             m_left;
  logic [W-1:0]   m_q;
  logic [W-1:0]   m_r;
  logic [2*W-1:0] p_qr;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy  <= 1'b0;
      m_valid <= 1'b0;
      m_left  <= 0;
      m_q     <= '0;
      m_r     <= '0;
    end else if (flush) begin
      m_busy  <= 1'b0;
      m_valid <= 1'b0;
      m_q     <= '0;
      m_r     <= '0;
    end else if (m_valid) begin
      if (ack) m_valid <= 1'b0;
    end else if (m_busy) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_busy  <= 1'b0;
        m_valid <= 1'b1;
        m_q     <= p_qr[2*W-1:W];
        m_r     <= p_qr[W-1:0];
      end
    end else if (start) begin
      if (divisor == '0) begin
        m_valid <= 1'b1;
        m_q     <= '1;
        m_r     <= dividend;
      end else begin
        m_busy <= 1'b1;
        m_left <= W;
        p_qr   <= ref_qr(is_signed, dividend, divisor);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("valid", result_valid, m_valid);
      check("stall", div_stall, !flush && (m_busy || (!m_valid && start)));
      if (m_valid) begin
        check("quotient", quotient, m_q);
        check("remainder", remainder, m_r);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_div(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int exp_lat, input logic [W-1:0] eq, input logic [W-1:0] er,
                         input string tag);
    int n;
    int stalls;
    is_signed = s;
    dividend  = a;
    divisor   = b;
    start     = 1'b1;
    n         = 0;
    stalls    = 0;
    while (n < 60) begin
      @(negedge clk);
      if (div_stall) stalls++;
      tick();
      n++;
      if (result_valid) break;
    end
    start = 1'b0;
    check({tag, " latency"}, n, exp_lat);
    check({tag, " stall cycles"}, stalls, exp_lat);
    check({tag, " q"}, quotient, eq);
    check({tag, " r"}, remainder, er);
    if (ack) begin
      tick();
      check({tag, " back to idle"}, result_valid, 1'b0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int vcnt;
    rst       = 1'b1;
    start     = 1'b0;
    is_signed = 1'b0;
    dividend  = '0;
    divisor   = '0;
    ack       = 1'b1;
    flush     = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    check("reset valid", result_valid, 1'b0);
    check("reset q", quotient, '0);
    check("reset r", remainder, '0);
    check("reset stall", div_stall, 1'b0);

    run_div(1'b0, 32'd100, 32'd7, 33, 32'd14, 32'd2, "divu 100/7");
    run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFD, 32'hFFFF_FFFF, "div -7/2");
    run_div(1'b1, 32'd7, 32'hFFFF_FFFE, 33, 32'hFFFF_FFFD, 32'd1, "div 7/-2");
    run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h8000_0000, 32'd0, "div min/-1");
    run_div(1'b0, 32'd5, 32'd0, 1, 32'hFFFF_FFFF, 32'd5, "divu 5/0");
    run_div(1'b1, 32'hFFFF_FFFB, 32'd0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFB, "div -5/0");
    run_div(1'b0, 32'hFFFF_FFFF, 32'h10, 33, 32'h0FFF_FFFF, 32'hF, "divu max/16");
    run_div(1'b0, 32'd7, 32'd9, 33, 32'd0, 32'd7, "divu 7/9");

    // Result held in DONE while the E stage is stalled; start stays up but is ignored.
    ack = 1'b0;
    run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFD, 32'hFFFF_FFFF, "hold -7/2");
    start    = 1'b1;
    dividend = 32'd123;
    divisor  = 32'd4;
    repeat (4) begin
      tick();
      check("hold valid", result_valid, 1'b1);
      check("hold q", quotient, 32'hFFFF_FFFD);
      check("hold r", remainder, 32'hFFFF_FFFF);
      check("hold stall", div_stall, 1'b0);
    end
    ack   = 1'b1;
    start = 1'b0;
    tick();
    check("hold released", result_valid, 1'b0);

    // Asynchronous reset in the middle of an iteration.
    is_signed = 1'b1;
    dividend  = 32'd50;
    divisor   = 32'd5;
    start     = 1'b1;
    repeat (6) tick();
    #3;
    rst = 1'b1;
    #1;
    check("async rst valid", result_valid, 1'b0);
    check("async rst q", quotient, '0);
    check("async rst r", remainder, '0);
    check("async rst stall", div_stall, 1'b0);
    dividend = 32'd1000;
    divisor  = 32'hFFFF_FFFD;
    tick();
    rst = 1'b0;
    run_div(1'b1, 32'd1000, 32'hFFFF_FFFD, 33, 32'hFFFF_FEB3, 32'd1, "post-rst 1000/-3");

    // Flush ten cycles into an iteration: nothing is ever reported.
    is_signed = 1'b0;
    dividend  = 32'd1000;
    divisor   = 32'd3;
    start     = 1'b1;
    repeat (10) tick();
    flush = 1'b1;
    start = 1'b0;
    #1;
    check("flush stall", div_stall, 1'b0);
    tick();
    flush = 1'b0;
    check("flush valid", result_valid, 1'b0);
    check("flush q", quotient, '0);
    check("flush r", remainder, '0);
    vcnt = 0;
    repeat (40) begin
      tick();
      if (result_valid) vcnt++;
    end
    check("flush no result", vcnt, 0);

    // Start coinciding with flush in IDLE is dropped.
    dividend = 32'd9;
    divisor  = 32'd3;
    start    = 1'b1;
    flush    = 1'b1;
    tick();
    start = 1'b0;
    flush = 1'b0;
    vcnt  = 0;
    repeat (36) begin
      tick();
      if (result_valid) vcnt++;
    end
    check("flush+start ignored", vcnt, 0);

    run_div(1'b0, 32'd9, 32'd3, 33, 32'd3, 32'd0, "divu 9/3");

    repeat (2) tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
